// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg: shared definitions for the fetch/decode/issue sequencer.
//   state_t      - sequencer FSM states
//   *_BIT/MSB/LSB - instruction field positions (20-bit word)
//   OP_*         - opcode encodings, shared with the control unit
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_WB,
    S_HALTED
  } state_t;

  localparam int unsigned HALT_BIT = 19;
  localparam int unsigned OPC_MSB  = 18;
  localparam int unsigned OPC_LSB  = 16;
  localparam int unsigned A_MSB    = 15;
  localparam int unsigned A_LSB    = 8;
  localparam int unsigned B_MSB    = 7;
  localparam int unsigned B_LSB    = 0;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: program-memory read bus plus issue/writeback handshake.
//   master (sequencer): drives imem_rd_en, imem_addr, opcode, a, b,
//                       issue_valid, wb_en; receives imem_rdata, issue_ready
//   slave  (memory/execute side): the mirror image
interface fetch_sequencer_if #(
  parameter int unsigned PC_W    = 4,
  parameter int unsigned INSTR_W = 20
);
  logic               imem_rd_en;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic [2:0]         opcode;
  logic [7:0]         a;
  logic [7:0]         b;
  logic               issue_valid;
  logic               issue_ready;
  logic               wb_en;

  modport master (
    output imem_rd_en, imem_addr, opcode, a, b, issue_valid, wb_en,
    input  imem_rdata, issue_ready
  );

  modport slave (
    input  imem_rd_en, imem_addr, opcode, a, b, issue_valid, wb_en,
    output imem_rdata, issue_ready
  );
endinterface

// File: rtl/fetch_seq_pc.sv
// fetch_seq_pc: program counter register.
//   clk, reset_n : clock, async active-low reset (pc -> 0)
//   clr          : synchronous clear to 0 (has priority over inc)
//   inc          : advance by one, wrapping modulo 2**PC_W
//   pc           : current program counter
//   pc_inc       : pc + 1 (wrapped), used to pre-load the fetch address
module fetch_seq_pc #(
  parameter int unsigned PC_W = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clr,
  input  logic            inc,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_inc
);

  assign pc_inc = pc + PC_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= '0;
    end else if (clr) begin
      pc <= '0;
    end else if (inc) begin
      pc <= pc_inc;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetches instruction words from synchronous program memory,
// decodes opcode/a/b, issues them over a valid/ready handshake and pulses a
// one-cycle writeback strobe; stops on a halt-flagged instruction.
//   clk, reset_n : clock, async active-low reset
//   start        : begin execution at address 0 (honoured in IDLE/HALTED only)
//   bus          : fetch_sequencer_if.master (imem read bus, issue, wb_en)
//   pc           : current program counter
//   busy, halted : status (busy = not IDLE/HALTED)
//   retire_cnt   : saturating retired-instruction count, only when
//                  FETCH_SEQ_PERF_EN is defined
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int unsigned PC_W    = 4,
  parameter int unsigned INSTR_W = 20
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  fetch_sequencer_if.master bus,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted
`ifdef FETCH_SEQ_PERF_EN
  ,
  output logic [15:0]     retire_cnt
`endif
);

  state_t             state;
  logic [INSTR_W-2:0] ir;
  logic [PC_W-1:0]    pc_inc;
  logic               start_ok;
  logic               pc_inc_en;

  assign start_ok  = start && (state == S_IDLE || state == S_HALTED);
  assign pc_inc_en = (state == S_WB);

  fetch_seq_pc #(.PC_W(PC_W)) u_pc (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (start_ok),
    .inc    (pc_inc_en),
    .pc     (pc),
    .pc_inc (pc_inc)
  );

  // The instruction register holds only the issuable payload; a halt word
  // is not loaded so opcode/a/b keep the last issued values.
  assign bus.opcode = ir[OPC_MSB:OPC_LSB];
  assign bus.a      = ir[A_MSB:A_LSB];
  assign bus.b      = ir[B_MSB:B_LSB];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      ir              <= '0;
      bus.issue_valid <= 1'b0;
      bus.wb_en       <= 1'b0;
      bus.imem_rd_en  <= 1'b0;
      bus.imem_addr   <= '0;
      busy            <= 1'b0;
      halted          <= 1'b0;
    end else begin
      bus.imem_rd_en <= 1'b0;
      bus.wb_en      <= 1'b0;
      case (state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            state          <= S_FETCH;
            bus.imem_rd_en <= 1'b1;
            bus.imem_addr  <= '0;
            busy           <= 1'b1;
            halted         <= 1'b0;
          end
        end
        S_FETCH: state <= S_LATCH;
        S_LATCH: begin
          if (bus.imem_rdata[HALT_BIT]) begin
            state  <= S_HALTED;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state           <= S_ISSUE;
            ir              <= bus.imem_rdata[INSTR_W-2:0];
            bus.issue_valid <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (bus.issue_ready) begin
            state           <= S_WB;
            bus.issue_valid <= 1'b0;
            bus.wb_en       <= 1'b1;
          end
        end
        S_WB: begin
          // pc advances on this edge; fetch address is pre-loaded to match.
          state          <= S_FETCH;
          bus.imem_rd_en <= 1'b1;
          bus.imem_addr  <= pc_inc;
        end
        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retire_cnt <= '0;
    end else if (start_ok) begin
      retire_cnt <= '0;
    end else if (bus.wb_en && retire_cnt != '1) begin
      retire_cnt <= retire_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  logic start, start2;
  logic [3:0] pc;
  logic [1:0] pc2;
  logic busy, halted, busy2, halted2;
`ifdef FETCH_SEQ_PERF_EN
  logic [15:0] retire_cnt, retire_cnt2;
`endif

  logic [19:0] mem  [16];
  logic [19:0] mem2 [4];
  int applied = 0;
  int errs    = 0;
  int wb_cnt  = 0;

  always #5 clk = ~clk;

  fetch_sequencer_if #(.PC_W(4), .INSTR_W(20)) bus  ();
  fetch_sequencer_if #(.PC_W(2), .INSTR_W(20)) bus2 ();

  fetch_sequencer #(.PC_W(4), .INSTR_W(20)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .bus(bus),
    .pc(pc), .busy(busy), .halted(halted)
`ifdef FETCH_SEQ_PERF_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  fetch_sequencer #(.PC_W(2), .INSTR_W(20)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .bus(bus2),
    .pc(pc2), .busy(busy2), .halted(halted2)
`ifdef FETCH_SEQ_PERF_EN
    , .retire_cnt(retire_cnt2)
`endif
  );

  // synchronous program memories: data valid the cycle after a read enable
  always @(posedge clk) if (bus.imem_rd_en)  bus.imem_rdata  <= mem[bus.imem_addr];
  always @(posedge clk) if (bus2.imem_rd_en) bus2.imem_rdata <= mem2[bus2.imem_addr];

  always @(negedge clk) if (bus.wb_en === 1'b1) wb_cnt++;

  typedef struct {
    logic [19:0] instr;
    int          stall;
    logic [2:0]  exp_opc;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [3:0]  exp_pc;
  } vec_t;

  vec_t vecs [3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int w;
    logic [1:0] k2;

    // sub 0A,07 / mul FF,80 (5 stall cycles) / cmp 12,34 (start pulsed in ISSUE)
    vecs[0] = '{20'h10A07, 0, 3'd1, 8'h0A, 8'h07, 4'd0};
    vecs[1] = '{20'h5FF80, 5, 3'd5, 8'hFF, 8'h80, 4'd1};
    vecs[2] = '{20'h71234, 2, 3'd7, 8'h12, 8'h34, 4'd2};

    for (int i = 0; i < 16; i++) mem[i] = 20'h80000;
    mem[0] = 20'h00503;
    mem[1] = 20'h80000;
    mem2[0] = 20'h00101; mem2[1] = 20'h10202; mem2[2] = 20'h20303; mem2[3] = 20'h30404;

    reset_n = 1'b0; start = 1'b0; start2 = 1'b0;
    bus.issue_ready = 1'b0; bus2.issue_ready = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // reset state
    check("rst_opcode", bus.opcode, 0);
    check("rst_a", bus.a, 0);
    check("rst_b", bus.b, 0);
    check("rst_valid", bus.issue_valid, 0);
    check("rst_wb", bus.wb_en, 0);
    check("rst_rd_en", bus.imem_rd_en, 0);
    check("rst_addr", bus.imem_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", pc, 0);

    // add 5,3 then halt, ready held high
    bus.issue_ready = 1'b1;
    start = 1'b1;
    tick(); start = 1'b0;
    check("c1_rd_en", bus.imem_rd_en, 1);
    check("c1_addr", bus.imem_addr, 0);
    check("c1_busy", busy, 1);
    tick();
    check("c2_rd_en", bus.imem_rd_en, 0);
    check("c2_valid", bus.issue_valid, 0);
    tick();
    check("c3_valid", bus.issue_valid, 1);
    check("c3_opcode", bus.opcode, 0);
    check("c3_a", bus.a, 5);
    check("c3_b", bus.b, 3);
    check("c3_wb", bus.wb_en, 0);
    tick();
    check("c4_wb", bus.wb_en, 1);
    check("c4_valid", bus.issue_valid, 0);
    tick();
    check("c5_wb", bus.wb_en, 0);
    check("c5_rd_en", bus.imem_rd_en, 1);
    check("c5_addr", bus.imem_addr, 1);
    check("c5_pc", pc, 1);
    tick(); tick();
    check("halt_halted", halted, 1);
    check("halt_busy", busy, 0);
    check("halt_pc", pc, 1);
    check("halt_valid", bus.issue_valid, 0);
    check("halt_wb_count", wb_cnt, 1);
`ifdef FETCH_SEQ_PERF_EN
    check("perf_first", retire_cnt, 1);
`endif

    // table-driven program with backpressure, restarted from HALTED
    for (int i = 0; i < 3; i++) mem[i] = vecs[i].instr;
    mem[3] = 20'h80000;
    bus.issue_ready = 1'b0;
    start = 1'b1;
    tick(); start = 1'b0;
    check("restart_rd_en", bus.imem_rd_en, 1);
    check("restart_addr", bus.imem_addr, 0);
    check("restart_pc", pc, 0);
    check("restart_halted", halted, 0);
`ifdef FETCH_SEQ_PERF_EN
    check("perf_cleared", retire_cnt, 0);
`endif
    for (int v = 0; v < 3; v++) begin
      cyc = 0;
      while (bus.issue_valid !== 1'b1 && cyc < 10) begin tick(); cyc++; end
      check("issue_seen", bus.issue_valid, 1);
      check("issue_latency", cyc, 2);
      check("issue_opcode", bus.opcode, vecs[v].exp_opc);
      check("issue_a", bus.a, vecs[v].exp_a);
      check("issue_b", bus.b, vecs[v].exp_b);
      check("issue_pc", pc, vecs[v].exp_pc);
      for (int s = 0; s < vecs[v].stall; s++) begin
        if (v == 2) start = 1'b1;
        tick();
        start = 1'b0;
        check("stall_valid", bus.issue_valid, 1);
        check("stall_wb", bus.wb_en, 0);
        check("stall_opcode", bus.opcode, vecs[v].exp_opc);
        check("stall_a", bus.a, vecs[v].exp_a);
        check("stall_b", bus.b, vecs[v].exp_b);
        check("stall_pc", pc, vecs[v].exp_pc);
      end
      bus.issue_ready = 1'b1;
      tick();
      bus.issue_ready = 1'b0;
      check("wb_pulse", bus.wb_en, 1);
      check("wb_valid", bus.issue_valid, 0);
      tick();
      check("wb_end", bus.wb_en, 0);
      check("next_rd_en", bus.imem_rd_en, 1);
      check("next_addr", bus.imem_addr, vecs[v].exp_pc + 4'd1);
      check("next_pc", pc, vecs[v].exp_pc + 4'd1);
    end
    tick(); tick();
    check("prog_halted", halted, 1);
    check("prog_pc", pc, 3);
    check("prog_busy", busy, 0);
    check("hold_opcode", bus.opcode, 7);
    check("hold_a", bus.a, 8'h12);
    check("hold_b", bus.b, 8'h34);
    check("prog_wb_count", wb_cnt, 4);
`ifdef FETCH_SEQ_PERF_EN
    check("perf_three", retire_cnt, 3);
`endif

    // PC_W=2 wrap: four non-halt words, ready tied high
    start2 = 1'b1;
    tick(); start2 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc = 0;
      while (bus2.imem_rd_en !== 1'b1 && cyc < 10) begin tick(); cyc++; end
      k2 = 2'(k);
      check("wrap_rd_en", bus2.imem_rd_en, 1);
      check("wrap_addr", bus2.imem_addr, k2);
      check("wrap_pc", pc2, k2);
      tick();
    end

    // async reset while stalled in ISSUE
    bus.issue_ready = 1'b0;
    start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    check("pre_rst_valid", bus.issue_valid, 1);
    tick();
    w = wb_cnt;
    #3 reset_n = 1'b0;
    #1;
    check("arst_valid", bus.issue_valid, 0);
    check("arst_opcode", bus.opcode, 0);
    check("arst_a", bus.a, 0);
    check("arst_b", bus.b, 0);
    check("arst_rd_en", bus.imem_rd_en, 0);
    check("arst_busy", busy, 0);
    check("arst_pc", pc, 0);
    bus.issue_ready = 1'b1;
    repeat (3) tick();
    check("arst_no_wb", wb_cnt, w);
    reset_n = 1'b1;
    tick(); tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_halted", halted, 0);
    check("post_rst_valid", bus.issue_valid, 0);
`ifdef FETCH_SEQ_PERF_EN
    check("perf_rst", retire_cnt, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
    $finish;
  end

endmodule
